// File: rtl/rpn_gw_pkg.sv
// ============================================================================
// Module  : rpn_gw_pkg
// Brief   : Shared types and round-robin helper for the gateway-to-network arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rpn_gw_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LAN  = 2'd1,
    ARB_WAN  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_LAN = 1'b0,
    SRC_WAN = 1'b1
  } src_sel_t;

  // With no requester the grant parks on LAN; it carries no beat in that case.
  function automatic src_sel_t rr_pick(input logic lan_valid, input logic wan_valid,
                                       input src_sel_t rr_last);
    if (lan_valid && wan_valid) return (rr_last == SRC_LAN) ? SRC_WAN : SRC_LAN;
    else if (wan_valid)         return SRC_WAN;
    else                        return SRC_LAN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rpn_gw_to_network_bridge_arbiter_if.sv
// ============================================================================
// Module  : rpn_gw_to_network_bridge_arbiter_if
// Brief   : AXI4-Stream bundle (tdata/tkeep/tid/tdest/tuser/tlast) with modports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rpn_gw_to_network_bridge_arbiter_if #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int IP_PORT_WIDTH    = 16,
  parameter int IP_ADDRESS_WIDTH = 32
);
  logic                        tvalid;
  logic                        tready;
  logic [AXIS_DATA_WIDTH-1:0]  tdata;
  logic [AXIS_KEEP_WIDTH-1:0]  tkeep;
  logic [IP_PORT_WIDTH-1:0]    tid;
  logic [IP_PORT_WIDTH-1:0]    tdest;
  logic [IP_ADDRESS_WIDTH-1:0] tuser;
  logic                        tlast;

  modport master (output tvalid, tdata, tkeep, tid, tdest, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tid, tdest, tuser, tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/rpn_gw_to_network_bridge_arbiter_skid_buffer.sv
// ============================================================================
// Module  : rpn_gw_axis_skid_buffer
// Brief   : Two-entry registered skid buffer; full rate, one cycle latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rpn_gw_axis_skid_buffer #(
  parameter int  AXIS_DATA_WIDTH  = 512,
  parameter int  AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int  IP_PORT_WIDTH    = 16,
  parameter int  IP_ADDRESS_WIDTH = 32,
  localparam int BEAT_W = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 2 * IP_PORT_WIDTH
                          + IP_ADDRESS_WIDTH + 1
) (
  input  wire logic              i_clk,
  input  wire logic              i_ap_rst_n,
  input  wire logic              i_valid,
  output logic                   o_ready,
  input  wire logic [BEAT_W-1:0] i_beat,
  output logic                   o_valid,
  input  wire logic              i_ready,
  output logic [BEAT_W-1:0]      o_beat
);

  logic [BEAT_W-1:0] r_head;
  logic [BEAT_W-1:0] r_tail;
  logic [1:0]        r_count;
  logic              r_in_ready;
  logic [1:0]        w_count_next;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_valid && r_in_ready;
  assign w_pop  = (r_count != 2'd0) && i_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // The head register drives the output; on a pop the tail slides forward first.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != 2'd2);
      if (w_pop) begin
        if (w_push && r_count == 2'd1) r_head <= i_beat;
        else                           r_head <= r_tail;
        if (w_push && r_count == 2'd2) r_tail <= i_beat;
      end else if (w_push) begin
        if (r_count == 2'd0) r_head <= i_beat;
        else                 r_tail <= i_beat;
      end
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_beat  = r_head;

endmodule

`default_nettype wire

// File: rtl/rpn_gw_to_network_bridge_arbiter.sv
// ============================================================================
// Module  : rpn_gw_to_network_bridge_arbiter
// Brief   : Packet-level round-robin merge of LAN RX and WAN TX onto the bridge.
//           Optional packet counters: define RPN_GW_ARB_PKT_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rpn_gw_to_network_bridge_arbiter
  import rpn_gw_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int IP_PORT_WIDTH    = 16,
  parameter int IP_ADDRESS_WIDTH = 32
) (
  input wire logic                            i_clk,
  input wire logic                            i_ap_rst_n,
  rpn_gw_to_network_bridge_arbiter_if.slave   from_rpn_LAN_RX,
  rpn_gw_to_network_bridge_arbiter_if.slave   from_rpn_WAN_TX,
  rpn_gw_to_network_bridge_arbiter_if.master  to_network_bridge
`ifdef RPN_GW_ARB_PKT_CNT_EN
  ,
  output logic [31:0]                         lan_pkt_cnt,
  output logic [31:0]                         wan_pkt_cnt
`endif
);

  localparam int BEAT_W = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 2 * IP_PORT_WIDTH
                          + IP_ADDRESS_WIDTH + 1;

  arb_state_t        r_state, w_state_next;
  src_sel_t          r_rr_last, w_rr_next;
  src_sel_t          w_grant;
  logic              w_src_valid;
  logic              w_src_last;
  logic              w_accept;
  logic              w_sk_ready;
  logic              w_out_valid;
  logic [BEAT_W-1:0] w_lan_beat, w_wan_beat, w_sk_beat, w_out_beat;

  assign w_lan_beat = {from_rpn_LAN_RX.tdata, from_rpn_LAN_RX.tkeep, from_rpn_LAN_RX.tid,
                       from_rpn_LAN_RX.tdest, from_rpn_LAN_RX.tuser, from_rpn_LAN_RX.tlast};
  assign w_wan_beat = {from_rpn_WAN_TX.tdata, from_rpn_WAN_TX.tkeep, from_rpn_WAN_TX.tid,
                       from_rpn_WAN_TX.tdest, from_rpn_WAN_TX.tuser, from_rpn_WAN_TX.tlast};

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      r_state   <= ARB_IDLE;
      r_rr_last <= SRC_WAN;
    end else begin
      r_state   <= w_state_next;
      r_rr_last <= w_rr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr_last;
    if (w_accept) begin
      if (w_src_last) begin
        w_state_next = ARB_IDLE;
        w_rr_next    = w_grant;
      end else begin
        w_state_next = (w_grant == SRC_LAN) ? ARB_LAN : ARB_WAN;
      end
    end
  end

  // Lock is held through tvalid gaps: grant only moves in IDLE.
  always_comb begin
    w_grant = SRC_LAN;
    case (r_state)
      ARB_LAN: w_grant = SRC_LAN;
      ARB_WAN: w_grant = SRC_WAN;
      default: w_grant = rr_pick(from_rpn_LAN_RX.tvalid, from_rpn_WAN_TX.tvalid, r_rr_last);
    endcase
    w_src_valid = (w_grant == SRC_LAN) ? from_rpn_LAN_RX.tvalid : from_rpn_WAN_TX.tvalid;
    w_src_last  = (w_grant == SRC_LAN) ? from_rpn_LAN_RX.tlast  : from_rpn_WAN_TX.tlast;
    w_sk_beat   = (w_grant == SRC_LAN) ? w_lan_beat : w_wan_beat;
    w_accept    = w_src_valid && w_sk_ready && i_ap_rst_n;
    from_rpn_LAN_RX.tready = w_sk_ready && i_ap_rst_n && (w_grant == SRC_LAN);
    from_rpn_WAN_TX.tready = w_sk_ready && i_ap_rst_n && (w_grant == SRC_WAN);
  end

  rpn_gw_axis_skid_buffer #(
    .AXIS_DATA_WIDTH  (AXIS_DATA_WIDTH),
    .AXIS_KEEP_WIDTH  (AXIS_KEEP_WIDTH),
    .IP_PORT_WIDTH    (IP_PORT_WIDTH),
    .IP_ADDRESS_WIDTH (IP_ADDRESS_WIDTH)
  ) u_skid (
    .i_clk      (i_clk),
    .i_ap_rst_n (i_ap_rst_n),
    .i_valid    (w_src_valid),
    .o_ready    (w_sk_ready),
    .i_beat     (w_sk_beat),
    .o_valid    (w_out_valid),
    .i_ready    (to_network_bridge.tready),
    .o_beat     (w_out_beat)
  );

  assign to_network_bridge.tvalid = w_out_valid;
  assign {to_network_bridge.tdata, to_network_bridge.tkeep, to_network_bridge.tid,
          to_network_bridge.tdest, to_network_bridge.tuser, to_network_bridge.tlast} = w_out_beat;

`ifdef RPN_GW_ARB_PKT_CNT_EN
  logic [31:0] r_lan_cnt;
  logic [31:0] r_wan_cnt;

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      r_lan_cnt <= 32'd0;
      r_wan_cnt <= 32'd0;
    end else if (w_accept && w_src_last) begin
      if (w_grant == SRC_LAN) r_lan_cnt <= r_lan_cnt + 32'd1;
      else                    r_wan_cnt <= r_wan_cnt + 32'd1;
    end
  end

  assign lan_pkt_cnt = r_lan_cnt;
  assign wan_pkt_cnt = r_wan_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rpn_gw_to_network_bridge_arbiter.sv
// ============================================================================
// Module  : tb_rpn_gw_to_network_bridge_arbiter
// Brief   : Scoreboard bench for the LAN/WAN packet arbiter (RPN_GW_ARB_PKT_CNT_EN optional).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rpn_gw_to_network_bridge_arbiter;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int PW = 16;
  localparam int AW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [PW-1:0] id;
    logic [PW-1:0] dest;
    logic [AW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rpn_gw_to_network_bridge_arbiter_if #(DW, KW, PW, AW) lan_if ();
  rpn_gw_to_network_bridge_arbiter_if #(DW, KW, PW, AW) wan_if ();
  rpn_gw_to_network_bridge_arbiter_if #(DW, KW, PW, AW) nb_if ();

`ifdef RPN_GW_ARB_PKT_CNT_EN
  logic [31:0] lan_pkt_cnt, wan_pkt_cnt;
`endif

  rpn_gw_to_network_bridge_arbiter #(
    .AXIS_DATA_WIDTH (DW), .AXIS_KEEP_WIDTH (KW), .IP_PORT_WIDTH (PW), .IP_ADDRESS_WIDTH (AW)
  ) dut (
    .i_clk             (clk),
    .i_ap_rst_n        (rst_n),
    .from_rpn_LAN_RX   (lan_if),
    .from_rpn_WAN_TX   (wan_if),
    .to_network_bridge (nb_if)
`ifdef RPN_GW_ARB_PKT_CNT_EN
    ,
    .lan_pkt_cnt       (lan_pkt_cnt),
    .wan_pkt_cnt       (wan_pkt_cnt)
`endif
  );

  int    n_cmp  = 0;
  int    n_fail = 0;
  beat_t exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int src, input logic [7:0] d, input logic last);
    beat_t b;
    b.data = {d, 496'h0, d};
    b.keep = last ? {32'h0, 32'hFFFF_FFFF} : '1;
    b.id   = (src == 0) ? 16'h00A1 : 16'h00B1;
    b.dest = {8'hD0, d};
    b.user = {((src == 0) ? 16'hCAFE : 16'hBEEF), 8'h00, d};
    b.last = last;
    return b;
  endfunction

  task automatic drive(input int src, input logic v, input logic [7:0] d, input logic last);
    beat_t b;
    b = mk_beat(src, d, last);
    if (src == 0) begin
      lan_if.tvalid = v; lan_if.tdata = b.data; lan_if.tkeep = b.keep; lan_if.tid = b.id;
      lan_if.tdest = b.dest; lan_if.tuser = b.user; lan_if.tlast = b.last;
    end else begin
      wan_if.tvalid = v; wan_if.tdata = b.data; wan_if.tkeep = b.keep; wan_if.tid = b.id;
      wan_if.tdest = b.dest; wan_if.tuser = b.user; wan_if.tlast = b.last;
    end
  endtask

  function automatic logic tready_of(input int src);
    return (src == 0) ? lan_if.tready : wan_if.tready;
  endfunction

  function automatic logic fire_of(input int src);
    return (src == 0) ? (lan_if.tvalid && lan_if.tready) : (wan_if.tvalid && wan_if.tready);
  endfunction

  // Call at posedge+1; returns at posedge+1 after the last beat is accepted.
  task automatic send_pkt(input int src, input logic [7:0] base, input int n,
                          input int gap_after, input int gap_len);
    for (int i = 0; i < n; i++) begin
      int t;
      drive(src, 1'b1, base + 8'(i), (i == n - 1));
      t = 0;
      @(negedge clk);
      while (!tready_of(src) && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        n_fail++;
        $display("FAIL src%0d_accept_timeout: beat %0d never accepted", src, i);
      end
      @(posedge clk); #1;
      if (i + 1 == gap_after && gap_len > 0) begin
        drive(src, 1'b0, 8'h00, 1'b0);
        repeat (gap_len) begin @(posedge clk); #1; end
      end
    end
    drive(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic push_exp(input int src, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(src, base + 8'(i), (i == n - 1)));
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(posedge clk); t++; end
    check(nm, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_tvalid", 64'(nb_if.tvalid), 64'd0);
    check("rst_out_tdata", nb_if.tdata[63:0], 64'd0);
    check("rst_out_tlast", 64'(nb_if.tlast), 64'd0);
    check("rst_lan_tready", 64'(lan_if.tready), 64'd0);
    check("rst_wan_tready", 64'(wan_if.tready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: every output handshake pops one expected beat.
  always @(negedge clk) begin
    if (rst_n && nb_if.tvalid && nb_if.tready) begin
      beat_t act, exp;
      act = {nb_if.tdata, nb_if.tkeep, nb_if.tid, nb_if.tdest, nb_if.tuser, nb_if.tlast};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %h expected nothing", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL out_beat: got %h expected %h", act, exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nb_if.tready = 1'b1;
    apply_reset();

    // 1: single LAN 3-beat packet, one-cycle latency, WAN never ready
    push_exp(0, 8'h11, 3);
    fork
      send_pkt(0, 8'h11, 3, 0, 0);
      begin
        int t = 0;
        @(negedge clk);
        while (!fire_of(0) && t < 50) begin @(negedge clk); t++; end
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("lat_tvalid", 64'(nb_if.tvalid), 64'd1);
          check("lat_tdata", 64'(nb_if.tdata[7:0]), 64'(8'h11 + 8'(k)));
        end
      end
      begin
        int c = 0;
        repeat (6) begin @(negedge clk); if (wan_if.tready) c++; end
        check("t1_wan_tready_count", 64'(c), 64'd0);
      end
    join
    wait_drain("t1_drain");

    // 2: simultaneous 2-beat packets after reset, LAN first, no interleave
    apply_reset();
    push_exp(0, 8'h21, 2);
    push_exp(1, 8'h31, 2);
    fork
      send_pkt(0, 8'h21, 2, 0, 0);
      send_pkt(1, 8'h31, 2, 0, 0);
    join
    wait_drain("t2_drain");

    // 3: continuous 1-beat packets alternate L,W,L,W...
    for (int k = 0; k < 4; k++) begin
      push_exp(0, 8'h40 + 8'(k), 1);
      push_exp(1, 8'h50 + 8'(k), 1);
    end
    fork
      for (int k = 0; k < 4; k++) send_pkt(0, 8'h40 + 8'(k), 1, 0, 0);
      for (int k = 0; k < 4; k++) send_pkt(1, 8'h50 + 8'(k), 1, 0, 0);
    join
    wait_drain("t3_drain");

    // 4: WAN stalls mid-packet; lock held, LAN waits
    push_exp(1, 8'h70, 4);
    push_exp(0, 8'h78, 1);
    fork
      send_pkt(1, 8'h70, 4, 2, 5);
      begin
        repeat (2) @(posedge clk);
        #1;
        send_pkt(0, 8'h78, 1, 0, 0);
      end
      begin
        int c = 0;
        repeat (2) @(posedge clk);
        #1;
        repeat (5) begin @(negedge clk); if (lan_if.tready) c++; end
        check("t4_lan_tready_in_gap", 64'(c), 64'd0);
      end
    join
    wait_drain("t4_drain");

    // 5: downstream back-pressure for 10 cycles during a 6-beat packet
    push_exp(0, 8'h60, 6);
    nb_if.tready = 1'b0;
    fork
      send_pkt(0, 8'h60, 6, 0, 0);
      begin
        int c = 0;
        repeat (10) begin @(negedge clk); if (fire_of(0)) c++; end
        check("t5_buffered_beats", 64'(c), 64'd2);
        check("t5_hold_tvalid", 64'(nb_if.tvalid), 64'd1);
        check("t5_hold_tdata", 64'(nb_if.tdata[7:0]), 64'h60);
        @(posedge clk); #1;
        nb_if.tready = 1'b1;
      end
    join
    wait_drain("t5_drain");

`ifdef RPN_GW_ARB_PKT_CNT_EN
    // 6: packet counters and asynchronous clear
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      push_exp(0, 8'h80 + 8'(k), 1);
      send_pkt(0, 8'h80 + 8'(k), 1, 0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      push_exp(1, 8'h90 + 8'(k), 1);
      send_pkt(1, 8'h90 + 8'(k), 1, 0, 0);
    end
    wait_drain("t6_drain");
    check("lan_pkt_cnt", 64'(lan_pkt_cnt), 64'd5);
    check("wan_pkt_cnt", 64'(wan_pkt_cnt), 64'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("lan_pkt_cnt_async_clr", 64'(lan_pkt_cnt), 64'd0);
    check("wan_pkt_cnt_async_clr", 64'(wan_pkt_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
